reg_bank_seq: RTL and testbench
===============================

# reg_bank_seq

Sequencer that executes single register-to-register operations against the 8 × 16-bit register bank. The bank has one shared address port, so each command is decomposed into read-A, optional read-B, execute and write-back cycles. The block sits between the command source (test driver or future decode stage) and the register bank. It owns the bank's address, read-enable, write-enable and write-data lines while busy.

## Interface
- Parameters: none; widths fixed (16-bit data, 3-bit register index, 3-bit opcode).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; command accepted on the edge where cmd_valid & cmd_ready
- cmd_op  in  3  opcode
- cmd_rd  in  3  destination register
- cmd_rs  in  3  source A
- cmd_rt  in  3  source B; ignored for unary ops
- bank_addr  out  3  bank address (drives the bank's shared read/write address port)
- bank_rd  out  1  bank read enable
- bank_wr  out  1  bank write enable (one-cycle pulse)
- bank_wdata  out  16  bank write data
- bank_rdata  in  16  bank read data; combinational from bank_addr while bank_rd high
- done  out  1  one-cycle pulse in the write-back cycle
- result  out  16  last computed result; holds until next EXE
- flag_z  out  1  result == 0 (REGSEQ_FLAGS_EN only)
- flag_c  out  1  carry/borrow/shift-out (REGSEQ_FLAGS_EN only)

## Operation
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 MOV: A
  - 6 SHL: A<<1, zero fill
  - 7 SHR: A>>1 logical
- MOV, SHL and SHR are unary and skip RDB.
- States (state register plus latched command fields op, rd, rs, rt):
  - IDLE: cmd_ready=1. On accept → RDA.
  - RDA: bank_addr=rs, bank_rd=1. Capture A from bank_rdata at the edge. → RDB if binary, else → EXE.
  - RDB: bank_addr=rt, bank_rd=1. Capture B. → EXE.
  - EXE: bank_rd=0, bank_wr=0. Compute and register result (and flags). → WB.
  - WB: bank_addr=rd, bank_wr=1, bank_wdata=result, done=1. → IDLE.
- Arithmetic: all results truncated to 16 bits. For every op, the A and B sources are the values read from the bank, including when rs==rt or rd==rs.
- bank_addr, bank_rd, bank_wr and done are decoded from the state register. They are glitch-free with respect to state, and no bank write occurs outside WB.
- cmd_valid while busy is ignored: no queuing, and no effect on the in-flight command.
- A command presented in the same cycle WB completes is accepted only on the following edge, when the block is back in IDLE.
- Reset, including mid-operation: immediately force state=IDLE with bank_wr=0, bank_rd=0 and done=0. The in-flight command is dropped with no partial write.
- Reset values:
  - cmd_ready=1
  - bank_addr=0
  - bank_wdata=0
  - result=0
  - flag_z=0
  - flag_c=0
  - A, B and latched fields =0

## Timing
- Accept edge = edge 0.
- Binary ops:
  - RDA during cycle 1, RDB cycle 2, EXE cycle 3, WB cycle 4.
  - done high in cycle 4; cmd_ready high again in cycle 5.
  - Throughput: one binary op per 5 cycles.
- Unary ops: WB in cycle 3; one unary op per 4 cycles.
- The bank captures the write at the edge ending WB.
- A read in the next command's RDA sees the new value (no forwarding needed).

## Configuration
- REGSEQ_FLAGS_EN defined:
  - flag_z and flag_c are registered at the EXE edge and hold until the next EXE.
  - flag_c by op:
    - ADD: carry-out of the 17-bit sum.
    - SUB: 1 when A<B unsigned (borrow).
    - SHL: A[15].
    - SHR: A[0].
    - Logical ops and MOV: 0.
- Undefined: flag_z and flag_c are tied to 0, and no flag logic is synthesised.

## Structure
- Package regseq_pkg:
  - opcode constants OP_ADD..OP_SHR
  - state encoding IDLE/RDA/RDB/EXE/WB
  - function is_unary(op)
- Sub-module regseq_alu: combinational; inputs op, A, B; outputs result and carry.
- The FSM, operand registers and bank-port decode stay in reg_bank_seq.

## Test plan
- Bank preloaded r1=0x0005, r2=0x0003; ADD rd=3 rs=1 rt=2 → done at cycle 4, r3=0x0008, flag_z=0, flag_c=0, 5-cycle spacing to next accept.
- r1=0x0003, r2=0x0005; SUB rd=4 → r4=0xFFFE, flag_c=1. Then XOR rd=5 rs=1 rt=1 → r5=0x0000, flag_z=1.
- r6=0x8001; SHL rd=7 rs=6 → no RDB cycle, done at cycle 3, r7=0x0002, flag_c=1. SHR rd=7 rs=6 → r7=0x4000, flag_c=1.
- ADD rd=1 rs=1 rt=1 with r1=0x7FFF → r1=0xFFFE. A following MOV rd=2 rs=1 → r2=0xFFFE (back-to-back write-then-read).
- cmd_valid held high with changing fields during a busy ADD → only the first command executes; no extra bank_wr pulses.
- reset asserted asynchronously during RDB → bank_wr never pulses, destination unchanged, cmd_ready=1 after reset release, next command runs normally.

Source files
------------

// File: rtl/regseq_pkg.sv
// Shared types and constants for the register-bank sequencer.
package regseq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_MOV = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        EXE  = 3'd3,
        WB   = 3'd4
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } cmd_t;

    // Unary ops never read a second operand, so they skip the RDB cycle.
    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_MOV) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer: result plus carry/borrow/shift-out.
module regseq_alu
    import regseq_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam int unsigned SUM_W = DATA_W + 1;

    logic [SUM_W-1:0] sum;

    assign sum = SUM_W'(a) + SUM_W'(b);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/reg_bank_seq.sv
// Sequences one register-to-register op over a single-port 8x16 register bank.
// Optional status flags are built when REGSEQ_FLAGS_EN is defined.
module reg_bank_seq
    import regseq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_W-1:0]  cmd_rd,
    input  logic [REG_W-1:0]  cmd_rs,
    input  logic [REG_W-1:0]  cmd_rt,
    output logic [REG_W-1:0]  bank_addr,
    output logic              bank_rd,
    output logic              bank_wr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    regseq_alu u_alu (
        .op     (cmd_q.op),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Next state and operand/result capture.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d   = '{op: cmd_op, rd: cmd_rd, rs: cmd_rs, rt: cmd_rt};
                    state_d = RDA;
                end
            end
            RDA: begin
                a_d     = bank_rdata;
                state_d = is_unary(cmd_q.op) ? EXE : RDB;
            end
            RDB: begin
                b_d     = bank_rdata;
                state_d = EXE;
            end
            EXE: begin
                result_d = alu_result;
                state_d  = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bank port and handshake decoded purely from the state register.
    always_comb begin
        cmd_ready = 1'b0;
        bank_addr = '0;
        bank_rd   = 1'b0;
        bank_wr   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            RDA: begin
                bank_addr = cmd_q.rs;
                bank_rd   = 1'b1;
            end
            RDB: begin
                bank_addr = cmd_q.rt;
                bank_rd   = 1'b1;
            end
            WB: begin
                bank_addr = cmd_q.rd;
                bank_wr   = 1'b1;
                done      = 1'b1;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    assign bank_wdata = result_q;
    assign result     = result_q;

`ifdef REGSEQ_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (state_q == EXE) begin
            flag_z_d = (alu_result == '0);
            flag_c_d = alu_carry;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    logic carry_unused;

    assign carry_unused = alu_carry;
    assign flag_z       = 1'b0;
    assign flag_c       = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_seq.sv
// Scoreboard bench for reg_bank_seq with a behavioural bank and reference register file.
module tb_reg_bank_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
    logic [2:0]  bank_addr;
    logic        bank_rd, bank_wr;
    logic [15:0] bank_wdata, bank_rdata;
    logic        done;
    logic [15:0] result;
    logic        flag_z, flag_c;

    reg_bank_seq dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .bank_addr  (bank_addr),
        .bank_rd    (bank_rd),
        .bank_wr    (bank_wr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .done       (done),
        .result     (result),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural bank: preload port has priority, used only while the DUT is idle.
    logic [15:0] bank [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [15:0] pre_data = 16'd0;

    always @(posedge clk) begin
        if (pre_we) bank[pre_addr] <= pre_data;
        else if (bank_wr) bank[bank_addr] <= bank_wdata;
    end
    assign bank_rdata = bank_rd ? bank[bank_addr] : 16'hDEAD;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
        bit          z;
        bit          c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          ref_regs [8];
    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    int          pushed = 0;
    int          last_acc = 0;
    int          last_lat = 0;
    bit          gap_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference semantics from the opcode table, on plain unsigned integers.
    function automatic void model(input int op, input int a, input int b,
                                  output int r, output bit c);
        c = 1'b0;
        case (op)
            0: begin r = a + b;          c = (r > 65535);  end
            1: begin r = a - b + 65536;  c = (a < b);      end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            6: begin r = a * 2;          c = (a >= 32768); end
            default: begin r = a / 2;    c = (a % 2 == 1); end
        endcase
        r = r % 65536;
    endfunction

    // Monitor: every write-back is popped against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bank_wr) wr_count++;
            check("wr_vs_done", 32'(bank_wr), 32'(done));
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_addr", 32'(bank_addr), 32'(e.rd));
                    check("wb_data", 32'(bank_wdata), 32'(e.val));
                    check("result", 32'(result), 32'(e.val));
                    check("done_latency", 32'(cyc - e.acc), 32'(e.lat));
`ifdef REGSEQ_FLAGS_EN
                    check("flag_z", 32'(flag_z), 32'(e.z));
                    check("flag_c", 32'(flag_c), 32'(e.c));
`else
                    check("flags_tied", {30'd0, flag_z, flag_c}, 32'd0);
`endif
                end
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (!(cmd_ready && exp_q.size() == 0) && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", 32'(cmd_ready && exp_q.size() == 0), 32'd1);
    endtask

    task automatic preload(input int a, input int d);
        wait_idle();
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 3'(a); pre_data = 16'(d);
        @(negedge clk);
        pre_we = 1'b0;
        ref_regs[a] = d;
        gap_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command; with noise, keep cmd_valid high with random fields while busy.
    task automatic issue(input int op, input int rd, input int rs, input int rt, input bit noise);
        int   r;
        bit   c;
        exp_t x;
        wait_ready();
        model(op, ref_regs[rs], (op >= 5) ? 0 : ref_regs[rt], r, c);
        cmd_valid = 1'b1;
        cmd_op = 3'(op); cmd_rd = 3'(rd); cmd_rs = 3'(rs); cmd_rt = 3'(rt);
        @(posedge clk);
        #1;
        x.rd = 3'(rd); x.val = 16'(r); x.z = (r == 0); x.c = c;
        x.lat = (op >= 5) ? 2 : 3;
        x.acc = cyc;
        if (gap_valid) check("accept_gap", 32'(x.acc - last_acc), 32'(last_lat + 2));
        exp_q.push_back(x);
        pushed++;
        ref_regs[rd] = r;
        last_acc = x.acc;
        last_lat = x.lat;
        gap_valid = !noise;
        if (noise) begin
            int g = 0;
            @(negedge clk);
            while (!cmd_ready && g < 20) begin
                cmd_op = 3'($urandom_range(0, 7)); cmd_rd = 3'($urandom_range(0, 7));
                cmd_rs = 3'($urandom_range(0, 7)); cmd_rt = 3'($urandom_range(0, 7));
                @(negedge clk);
                g++;
            end
        end
        cmd_valid = 1'b0;
    endtask

    // Command reset away during RDB: no write, nothing expected.
    task automatic reset_during_rdb(input int rd, input int rs, input int rt);
        int wr_before;
        wait_idle();
        wait_ready();
        wr_before = wr_count;
        cmd_valid = 1'b1;
        cmd_op = 3'd0; cmd_rd = 3'(rd); cmd_rs = 3'(rs); cmd_rt = 3'(rt);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        check("in_rdb_before_reset", {29'd0, bank_rd, bank_addr == 3'(rt), cmd_ready}, 32'd6);
        reset = 1'b1;
        #1;
        check("mid_reset_ports", {28'd0, cmd_ready, bank_rd, bank_wr, done}, 32'd8);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("ready_after_reset", 32'(cmd_ready), 32'd1);
        repeat (6) @(negedge clk);
        check("no_write_on_drop", 32'(wr_count), 32'(wr_before));
        check("dest_unchanged", 32'(bank[rd]), 32'(ref_regs[rd]));
        gap_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_ctrl", {29'd0, bank_rd, bank_wr, done}, 32'd0);
        check("rst_addr", 32'(bank_addr), 32'd0);
        check("rst_wdata", 32'(bank_wdata), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) preload(i, int'($urandom_range(0, 65535)));

        // ADD then back-to-back SUB and XOR (5-cycle spacing checked).
        preload(1, 16'h0005);
        preload(2, 16'h0003);
        issue(0, 3, 1, 2, 1'b0);
        issue(1, 4, 2, 1, 1'b0);
        issue(4, 5, 1, 1, 1'b0);
        // Unary shifts: no RDB, 4-cycle spacing.
        preload(6, 16'h8001);
        issue(6, 7, 6, 0, 1'b0);
        issue(7, 7, 6, 0, 1'b0);
        // Self-referencing ADD then MOV reading the freshly written value.
        preload(1, 16'h7FFF);
        issue(0, 1, 1, 1, 1'b0);
        issue(5, 2, 1, 0, 1'b0);
        // cmd_valid held during a busy ADD.
        issue(0, 6, 3, 4, 1'b1);
        // Async reset during RDB, then a normal command.
        reset_during_rdb(0, 2, 3);
        issue(1, 0, 2, 3, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int d = $urandom_range(0, 2);
            if (d != 0) begin
                repeat (d) @(negedge clk);
                gap_valid = 1'b0;
            end
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(wr_count), 32'(pushed));
        for (int i = 0; i < 8; i++) check("final_bank", 32'(bank[i]), 32'(ref_regs[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
